// File: rtl/flit_input_buffer_if.sv
// Flit presentation bus between the input buffer and the switch allocator.
// The buffer drives the head-of-FIFO flit; the allocator answers with a grant.
interface flit_input_buffer_if #(
   parameter int TDEST_WIDTH = 3,
   parameter int TDATA_WIDTH = 512
);

   logic                   flit_valid;
   logic [TDATA_WIDTH-1:0] flit_data;
   logic [TDEST_WIDTH-1:0] flit_dest;
   logic                   flit_is_head;
   logic                   flit_is_tail;
   logic                   flit_ready;

   modport master (
      output flit_valid,
      output flit_data,
      output flit_dest,
      output flit_is_head,
      output flit_is_tail,
      input  flit_ready
   );

   modport slave (
      input  flit_valid,
      input  flit_data,
      input  flit_dest,
      input  flit_is_head,
      input  flit_is_tail,
      output flit_ready
   );

endinterface

// File: rtl/flit_input_buffer.sv
// Router input-port flit buffer: credit-flow-controlled show-ahead FIFO that
// presents its head flit to the switch allocator with a wormhole route lock
// (the head flit's destination is reused for every body flit up to the tail).
module flit_input_buffer #(
   parameter int TDEST_WIDTH       = 3,
   parameter int TDATA_WIDTH       = 512,
   parameter int FLIT_BUFFER_DEPTH = 4,
   parameter int PTR_WIDTH         = 2,
   parameter int COUNT_WIDTH       = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [TDATA_WIDTH-1:0] data_in,
   input  logic [TDEST_WIDTH-1:0] dest_in,
   input  logic                   is_tail_in,
   input  logic                   send_in,
   output logic                   credit_out,
   output logic                   pkt_complete,
   output logic                   overflow_err,
   flit_input_buffer_if.master    flit_bus
);

   typedef enum logic {HEAD, BODY} route_state_t;

   localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(FLIT_BUFFER_DEPTH);

   logic [TDATA_WIDTH-1:0] data_mem [FLIT_BUFFER_DEPTH];
   logic [TDEST_WIDTH-1:0] dest_mem [FLIT_BUFFER_DEPTH];
   logic                   tail_mem [FLIT_BUFFER_DEPTH];

   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic [COUNT_WIDTH-1:0] count;
   logic [COUNT_WIDTH-1:0] tails;
   logic [TDEST_WIDTH-1:0] route_reg;

   route_state_t state;
   route_state_t state_next;

   logic not_empty;
   logic full;
   logic push;
   logic pop;
   logic head_tail;

   assign not_empty = (count != '0);
   assign full      = (count == FULL_COUNT);
   assign pop       = not_empty & flit_bus.flit_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push      = send_in & (~full | pop);
   assign head_tail = tail_mem[rd_ptr];

   // Payload storage is written on accepted pushes only and needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= data_in;
         dest_mem[wr_ptr] <= dest_in;
         tail_mem[wr_ptr] <= is_tail_in;
      end
   end

   // Pointers, occupancy, buffered-tail count, credit return and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         tails        <= '0;
         credit_out   <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         case ({push, pop})
            2'b10:   count <= count + COUNT_WIDTH'(1);
            2'b01:   count <= count - COUNT_WIDTH'(1);
            default: count <= count;
         endcase
         case ({push & is_tail_in, pop & head_tail})
            2'b10:   tails <= tails + COUNT_WIDTH'(1);
            2'b01:   tails <= tails - COUNT_WIDTH'(1);
            default: tails <= tails;
         endcase
         credit_out <= pop;
         if (send_in & ~push) overflow_err <= 1'b1;
      end
   end

   // Route FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= HEAD;
      else     state <= state_next;
   end

   // Route FSM next state: a non-tail head opens a packet, a tail pop closes it.
   always_comb begin
      state_next = state;
      case (state)
         HEAD:    if (pop & ~head_tail) state_next = BODY;
         BODY:    if (pop & head_tail)  state_next = HEAD;
         default: state_next = HEAD;
      endcase
   end

   // Latch the head flit's destination when it departs so body flits follow it.
   always_ff @(posedge clk) begin
      if (rst)                                      route_reg <= '0;
      else if ((state == HEAD) && pop && !head_tail) route_reg <= dest_mem[rd_ptr];
   end

   // Route FSM outputs: stored destination while at a packet head, locked route otherwise.
   always_comb begin
      flit_bus.flit_is_head = 1'b1;
      flit_bus.flit_dest    = '0;
      case (state)
         HEAD: begin
            flit_bus.flit_is_head = 1'b1;
            flit_bus.flit_dest    = not_empty ? dest_mem[rd_ptr] : '0;
         end
         BODY: begin
            flit_bus.flit_is_head = 1'b0;
            flit_bus.flit_dest    = route_reg;
         end
         default: begin
            flit_bus.flit_is_head = 1'b1;
            flit_bus.flit_dest    = '0;
         end
      endcase
   end

   assign flit_bus.flit_valid   = not_empty;
   assign flit_bus.flit_data    = data_mem[rd_ptr];
   assign flit_bus.flit_is_tail = not_empty & head_tail;
   assign pkt_complete          = (tails != '0);

endmodule
